// File: rtl/id_operand_stage_if.sv
// id_operand_stage_if: IF/ID/EX handshake, decoder/regfile and forwarding bus of the operand stage.
interface id_operand_stage_if #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int NSRC      = 3,
    parameter int NFWD      = 3,
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = 16
);
    logic                   if_validout;
    logic [PAYLOAD_W-1:0]   if_to_id_bus;
    logic                   ex_allowin;
    logic                   id_allowin;
    logic                   id_validout;
    logic                   flush;
    logic [PAYLOAD_W-1:0]   payload_q;
    logic [NSRC*REG_AW-1:0] src_addr;
    logic [NSRC-1:0]        src_en;
    logic [NSRC*DATA_W-1:0] rf_rdata;
    logic [NFWD-1:0]        fwd_valid;
    logic [NFWD-1:0]        fwd_we;
    logic [NFWD*REG_AW-1:0] fwd_dest;
    logic [NFWD-1:0]        fwd_ready;
    logic [NFWD*DATA_W-1:0] fwd_data;
    logic [NSRC*DATA_W-1:0] opnd;
    logic [CNT_W-1:0]       stall_cnt;

    modport slave (
        input  if_validout, if_to_id_bus, ex_allowin, flush, src_addr, src_en, rf_rdata,
               fwd_valid, fwd_we, fwd_dest, fwd_ready, fwd_data,
        output id_allowin, id_validout, payload_q, opnd, stall_cnt
    );

    modport master (
        output if_validout, if_to_id_bus, ex_allowin, flush, src_addr, src_en, rf_rdata,
               fwd_valid, fwd_we, fwd_dest, fwd_ready, fwd_data,
        input  id_allowin, id_validout, payload_q, opnd, stall_cnt
    );
endinterface

// File: rtl/id_operand_stage.sv
// id_operand_stage: ID pipeline register with forwarding-based operand resolution; stalls only on unready producers.
module id_operand_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int NSRC      = 3,
    parameter int NFWD      = 3,
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = 16
) (
    input logic                clk,
    input logic                rst,
    id_operand_stage_if.slave  bus
);
    logic                   r_valid;
    logic [PAYLOAD_W-1:0]   r_payload;
    logic [CNT_W-1:0]       r_stall_cnt;
    logic [NSRC-1:0]        w_blocked;
    logic [NSRC*DATA_W-1:0] w_opnd;
    logic                   w_readygo;
    logic                   w_allowin;

    genvar k;
    for (k = 0; k < NSRC; k++) begin : g_src
        logic [REG_AW-1:0] w_addr;
        logic [DATA_W-1:0] w_sel;
        logic              w_blk;
        assign w_addr = bus.src_addr[k*REG_AW +: REG_AW];
        // Scan oldest to youngest so the youngest hit is the last one written.
        always_comb begin
            w_sel = bus.rf_rdata[k*DATA_W +: DATA_W];
            w_blk = 1'b0;
            for (int j = NFWD - 1; j >= 0; j--) begin
                if (bus.src_en[k] && w_addr != '0 && bus.fwd_valid[j] && bus.fwd_we[j] &&
                    bus.fwd_dest[j*REG_AW +: REG_AW] == w_addr) begin
                    w_sel = bus.fwd_data[j*DATA_W +: DATA_W];
                    w_blk = ~bus.fwd_ready[j];
                end
            end
        end
        assign w_opnd[k*DATA_W +: DATA_W] = (w_addr == '0) ? '0 : w_sel;
        assign w_blocked[k] = w_blk;
    end

    assign w_readygo       = ~|w_blocked;
    assign w_allowin       = ~r_valid | (w_readygo & bus.ex_allowin);
    assign bus.id_allowin  = w_allowin;
    assign bus.id_validout = r_valid & w_readygo & ~bus.flush;
    assign bus.payload_q   = r_payload;
    assign bus.opnd        = w_opnd;
    assign bus.stall_cnt   = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_payload   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (bus.flush)
                r_valid <= 1'b0;
            else if (w_allowin)
                r_valid <= bus.if_validout;
            if (bus.if_validout && w_allowin && !bus.flush)
                r_payload <= bus.if_to_id_bus;
            if (r_valid && !w_readygo && !bus.flush && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed scenario tests for the forwarding operand stage.
module tb_id_operand_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    id_operand_stage_if bus ();
    id_operand_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.if_validout  = 1'b0;
        bus.if_to_id_bus = '0;
        bus.ex_allowin   = 1'b1;
        bus.flush        = 1'b0;
        bus.src_addr     = '0;
        bus.src_en       = '0;
        bus.rf_rdata     = '0;
        bus.fwd_valid    = '0;
        bus.fwd_we       = '0;
        bus.fwd_dest     = '0;
        bus.fwd_ready    = '0;
        bus.fwd_data     = '0;
    endtask

    task automatic set_src(input int k, input logic [4:0] a, input logic en, input logic [31:0] rd);
        bus.src_addr[k*5 +: 5]   = a;
        bus.src_en[k]            = en;
        bus.rf_rdata[k*32 +: 32] = rd;
    endtask

    task automatic set_fwd(input int j, input logic v, input logic we, input logic [4:0] d,
                           input logic rdy, input logic [31:0] data);
        bus.fwd_valid[j]         = v;
        bus.fwd_we[j]            = we;
        bus.fwd_dest[j*5 +: 5]   = d;
        bus.fwd_ready[j]         = rdy;
        bus.fwd_data[j*32 +: 32] = data;
    endtask

    task automatic load(input logic [63:0] p);
        @(negedge clk);
        clear_inputs();
        bus.if_validout  = 1'b1;
        bus.if_to_id_bus = p;
        @(posedge clk);
        @(negedge clk);
        bus.if_validout = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (bus.id_validout !== 1'b0) begin bad++; $display("FAIL reset_validout got=%b want=0", bus.id_validout); end
        total++; if (bus.id_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b want=1", bus.id_allowin); end
        total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", bus.stall_cnt); end
        total++; if (bus.payload_q !== 64'd0) begin bad++; $display("FAIL reset_payload got=%h want=0", bus.payload_q); end
    endtask

    task automatic test_fwd_ex();
        load(64'h1000_0000_0000_0001);
        set_src(0, 5'd5, 1'b1, 32'hDEAD);
        set_fwd(0, 1'b1, 1'b1, 5'd5, 1'b1, 32'h1234);
        #1;
        total++; if (bus.opnd[31:0] !== 32'h1234) begin bad++; $display("FAIL fwd_ex_opnd got=%h want=1234", bus.opnd[31:0]); end
        total++; if (bus.id_validout !== 1'b1) begin bad++; $display("FAIL fwd_ex_validout got=%b want=1", bus.id_validout); end
        total++; if (bus.payload_q !== 64'h1000_0000_0000_0001) begin bad++; $display("FAIL fwd_ex_payload got=%h want=1000000000000001", bus.payload_q); end
    endtask

    task automatic test_priority();
        load(64'h2000_0000_0000_0002);
        set_src(0, 5'd5, 1'b1, 32'hDEAD);
        set_fwd(0, 1'b1, 1'b1, 5'd5, 1'b1, 32'hA);
        set_fwd(1, 1'b1, 1'b1, 5'd6, 1'b1, 32'hC);
        set_fwd(2, 1'b1, 1'b1, 5'd5, 1'b1, 32'hB);
        #1;
        total++; if (bus.opnd[31:0] !== 32'hA) begin bad++; $display("FAIL prio_youngest got=%h want=a", bus.opnd[31:0]); end
        bus.fwd_valid[0] = 1'b0;
        #1;
        total++; if (bus.opnd[31:0] !== 32'hB) begin bad++; $display("FAIL prio_oldest got=%h want=b", bus.opnd[31:0]); end
        bus.fwd_valid = '0;
        #1;
        total++; if (bus.opnd[31:0] !== 32'hDEAD) begin bad++; $display("FAIL prio_regfile got=%h want=dead", bus.opnd[31:0]); end
    endtask

    task automatic test_load_use();
        load(64'h3000_0000_0000_0003);
        set_src(1, 5'd7, 1'b1, 32'h99);
        set_fwd(0, 1'b1, 1'b1, 5'd7, 1'b0, 32'h77);
        set_fwd(2, 1'b1, 1'b1, 5'd7, 1'b1, 32'hAA);
        bus.if_validout  = 1'b1;
        bus.if_to_id_bus = 64'h3333_3333_3333_3333;
        #1;
        total++; if (bus.id_validout !== 1'b0) begin bad++; $display("FAIL lu_stall_validout got=%b want=0", bus.id_validout); end
        total++; if (bus.id_allowin !== 1'b0) begin bad++; $display("FAIL lu_stall_allowin got=%b want=0", bus.id_allowin); end
        @(posedge clk);
        @(negedge clk);
        total++; if (bus.payload_q !== 64'h3000_0000_0000_0003) begin bad++; $display("FAIL lu_payload_held got=%h want=3000000000000003", bus.payload_q); end
        set_fwd(0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
        set_fwd(1, 1'b1, 1'b1, 5'd7, 1'b1, 32'h55);
        bus.if_validout = 1'b0;
        #1;
        total++; if (bus.opnd[63:32] !== 32'h55) begin bad++; $display("FAIL lu_fwd_ma got=%h want=55", bus.opnd[63:32]); end
        total++; if (bus.id_validout !== 1'b1) begin bad++; $display("FAIL lu_resume_validout got=%b want=1", bus.id_validout); end
        total++; if (bus.stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d want=1", bus.stall_cnt); end
    endtask

    task automatic test_r0_disabled();
        load(64'h4000_0000_0000_0004);
        set_src(0, 5'd0, 1'b1, 32'hFFFF);
        set_fwd(0, 1'b1, 1'b1, 5'd0, 1'b0, 32'h1);
        #1;
        total++; if (bus.opnd[31:0] !== 32'h0) begin bad++; $display("FAIL r0_opnd got=%h want=0", bus.opnd[31:0]); end
        total++; if (bus.id_validout !== 1'b1) begin bad++; $display("FAIL r0_no_stall got=%b want=1", bus.id_validout); end
        set_src(0, 5'd9, 1'b0, 32'h1111);
        set_fwd(0, 1'b1, 1'b1, 5'd9, 1'b0, 32'h2);
        #1;
        total++; if (bus.id_validout !== 1'b1) begin bad++; $display("FAIL dis_no_stall got=%b want=1", bus.id_validout); end
        total++; if (bus.id_allowin !== 1'b1) begin bad++; $display("FAIL dis_allowin got=%b want=1", bus.id_allowin); end
        total++; if (bus.opnd[31:0] !== 32'h1111) begin bad++; $display("FAIL dis_opnd got=%h want=1111", bus.opnd[31:0]); end
    endtask

    task automatic test_flush();
        load(64'h5000_0000_0000_0005);
        set_src(0, 5'd3, 1'b1, 32'h0);
        set_fwd(0, 1'b1, 1'b1, 5'd3, 1'b0, 32'h0);
        bus.flush        = 1'b1;
        bus.if_validout  = 1'b1;
        bus.if_to_id_bus = 64'h5555_5555_5555_5555;
        #1;
        total++; if (bus.id_validout !== 1'b0) begin bad++; $display("FAIL flush_validout got=%b want=0", bus.id_validout); end
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        total++; if (bus.payload_q !== 64'h5000_0000_0000_0005) begin bad++; $display("FAIL flush_payload_held got=%h want=5000000000000005", bus.payload_q); end
        total++; if (bus.stall_cnt !== 16'd1) begin bad++; $display("FAIL flush_stall_cnt got=%0d want=1", bus.stall_cnt); end
        total++; if (bus.id_validout !== 1'b0 || bus.id_allowin !== 1'b1) begin bad++; $display("FAIL flush_dropped got=%b/%b want=0/1", bus.id_validout, bus.id_allowin); end
        @(posedge clk);
        @(negedge clk);
        bus.if_validout = 1'b0;
        bus.fwd_valid   = '0;
        #1;
        total++; if (bus.payload_q !== 64'h5555_5555_5555_5555) begin bad++; $display("FAIL flush_accept_payload got=%h want=5555555555555555", bus.payload_q); end
        total++; if (bus.id_validout !== 1'b1) begin bad++; $display("FAIL flush_accept_valid got=%b want=1", bus.id_validout); end
    endtask

    task automatic test_reset_mid_stall();
        load(64'h6000_0000_0000_0006);
        set_src(2, 5'd4, 1'b1, 32'h0);
        set_fwd(1, 1'b1, 1'b1, 5'd4, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        total++; if (bus.stall_cnt !== 16'd2) begin bad++; $display("FAIL rms_stall_cnt got=%0d want=2", bus.stall_cnt); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.fwd_valid = '0;
        #1;
        total++; if (bus.id_validout !== 1'b0 || bus.id_allowin !== 1'b1) begin bad++; $display("FAIL rms_dropped got=%b/%b want=0/1", bus.id_validout, bus.id_allowin); end
        total++; if (bus.payload_q !== 64'd0 || bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL rms_cleared got=%h/%0d want=0/0", bus.payload_q, bus.stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_fwd_ex();
        test_priority();
        test_load_use();
        test_r0_disabled();
        test_flush();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised successor to the stall-only decode stage: the ID pipeline register plus operand resolution.
- Resolves NSRC register source operands using a forwarding network from NFWD later stages, instead of stalling on every RAW hazard.
- Stalls only when the matching producer's data is not yet available (load-use).
- Sits between IF and EX. The external decoder reads payload_q combinationally and returns source addresses and enables; the external regfile returns raw read data.

Parameters:
- DATA_W, 32, operand/data width
- REG_AW, 5, register address width
- NSRC, 3, number of source operands resolved (rj, rk, rd)
- NFWD, 3, number of forwarding sources; index 0 is the youngest (EX), NFWD-1 the oldest (WB)
- PAYLOAD_W, 64, width of the IF-to-ID bus ({pc, inst})
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- if_validout  in  1  upstream payload valid
- if_to_id_bus  in  PAYLOAD_W  upstream payload
- ex_allowin  in  1  downstream ready
- id_allowin  out  1  stage can accept a payload this cycle
- id_validout  out  1  resolved operands valid to EX
- flush  in  1  cancel the in-stage instruction (branch taken here or later)
- payload_q  out  PAYLOAD_W  registered payload to the decoder and EX
- src_addr  in  NSRC*REG_AW  source addresses from the decoder, src k at [k*REG_AW +: REG_AW]
- src_en  in  NSRC  source k is actually read
- rf_rdata  in  NSRC*DATA_W  regfile read data per source
- fwd_valid  in  NFWD  producer stage holds a valid instruction
- fwd_we  in  NFWD  producer writes the register file
- fwd_dest  in  NFWD*REG_AW  producer destination register
- fwd_ready  in  NFWD  producer result is available this cycle (0 for a load still in EX)
- fwd_data  in  NFWD*DATA_W  producer result
- opnd  out  NSRC*DATA_W  resolved operand values
- stall_cnt  out  CNT_W  count of cycles with valid & ~readygo, saturating

Behaviour:
- Reset (rst==0 at a clk edge) sets:
  - valid=0
  - payload_q=0
  - stall_cnt=0
  - As a result, id_validout=0 and id_allowin=1.
- Match rule, per source k and stage j:
  - hit[k][j] = src_en[k] & (src_addr[k]!=0) & fwd_valid[j] & fwd_we[j] & (fwd_dest[j]==src_addr[k]).
- Selection:
  - The lowest index j with hit[k][j] wins (youngest producer).
  - opnd[k] = fwd_data[win] when any hit is present.
  - Otherwise opnd[k] = rf_rdata[k].
  - If src_addr[k]==0, opnd[k]=0 regardless of rf_rdata or forwarding.
- Hazard:
  - blocked[k] = any hit on k & ~fwd_ready[win]. An older ready match does not override a younger unready one.
  - readygo = ~|blocked. Sources with src_en=0 never block.
- Handshake:
  - id_allowin = ~valid | (readygo & ex_allowin).
  - id_validout = valid & readygo & ~flush.
  - Operands are purely combinational; EX latency is 0 cycles from the resolving cycle.
- Valid register update, in priority order:
  1. Reset.
  2. flush → valid<=0, and no payload is loaded that cycle.
  3. id_allowin → valid<=if_validout.
- Payload register: loads if_to_id_bus when if_validout & id_allowin & ~flush. Otherwise it holds.
- Stall:
  - While readygo=0, payload_q, valid and outputs hold. Resolution is re-evaluated every cycle as producers advance.
  - Example: a load in EX stalls the stage for 1 cycle, then forwards from MA once MA drives fwd_ready=1.
- stall_cnt: increments on valid & ~readygo & ~flush. It holds at 2^CNT_W-1 and clears only on reset.
- Simultaneous events:
  - flush with a stall → instruction dropped, stall count not incremented.
  - flush with ex_allowin=1 → nothing is issued (id_validout=0).
- Reset asserted mid-stall: on the next edge, valid=0 and the instruction is discarded.
- Parametrisation: NSRC, NFWD ≥ 1. All loops are generate- or for-based with no hard-coded stage names.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → id_validout=0, id_allowin=1, stall_cnt=0, payload_q=0.
- Forwarding from EX:
  - Setup: EX has valid=1, we=1, dest=5, ready=1, data=0x1234; the instruction reads src0=r5 with rf_rdata=0xDEAD.
  - Required response: opnd[0]=0x1234, id_validout=1 in the same cycle.
- Priority:
  - Setup: EX holds dest=5 with data=0xA, and WB holds dest=5 with data=0xB, both ready.
  - Required response: opnd=0xA.
  - Then clear EX valid → opnd=0xB.
- Load-use:
  - Setup: EX has dest=7 with ready=0, and src1=r7.
  - Required response: id_validout=0, id_allowin=0, payload_q held.
  - Next cycle, MA has dest=7, ready=1, data=0x55 → opnd[1]=0x55, id_validout=1, stall_cnt=1.
- r0 and disabled sources:
  - Setup: src_addr=0 with EX dest=0, we=1.
  - Required response: opnd=0, no stall.
  - Setup: src_en=0 with EX dest matching and ready=0 → no stall.
- Flush:
  - Setup: flush=1 during a stall, with if_validout=1.
  - Required response: next cycle valid=0, payload_q unchanged, stall_cnt not incremented.
  - The following cycle the stage accepts the new payload.
